// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single instruction/data memory port
// between the fetch stage and the memory stage.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   if_req, if_addr     fetch read request, held until if_done
//   if_rdata, if_done   fetched word (held) and one-cycle completion
//   mem_rd, mem_wr      data read / write request
//   mem_addr, mem_wdata data address and store data
//   mem_rdata, mem_done loaded word (held) and one-cycle completion
//   stall_if, stall_mem freeze a stage while its access is open
//   ram_en/we/addr/wdata  registered memory-side access
//   ram_rdata, ram_ready  memory answer; ready ends the access
module mem_port_arbiter #(
    parameter int ADDR_W          = 16,
    parameter int DATA_W          = 16,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_done,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_ready
);

    typedef enum logic [1:0] {IDLE, BUSY_D, BUSY_F, DONE} state_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

    state_t            state, stateNext;
    logic [3:0]        streak, streakNext;
    logic              ramEnNext, ramWeNext;
    logic              ifDoneNext, memDoneNext;
    logic [ADDR_W-1:0] ramAddrNext;
    logic [DATA_W-1:0] ramWdataNext, ifRdataNext, memRdataNext;
    logic              dataReq, grantData;

    assign dataReq   = mem_rd | mem_wr;
    // Data is older and wins, unless fetch is waiting and data has
    // already taken its full streak of grants.
    assign grantData = dataReq & ((streak < STREAK_MAX) | ~if_req);

    assign stall_if  = if_req & ~if_done;
    assign stall_mem = dataReq & ~mem_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            streak    <= '0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            if_done   <= 1'b0;
            mem_done  <= 1'b0;
            if_rdata  <= '0;
            mem_rdata <= '0;
        end else begin
            state     <= stateNext;
            streak    <= streakNext;
            ram_en    <= ramEnNext;
            ram_we    <= ramWeNext;
            ram_addr  <= ramAddrNext;
            ram_wdata <= ramWdataNext;
            if_done   <= ifDoneNext;
            mem_done  <= memDoneNext;
            if_rdata  <= ifRdataNext;
            mem_rdata <= memRdataNext;
        end
    end

    always_comb begin
        stateNext    = state;
        streakNext   = streak;
        ramEnNext    = ram_en;
        ramWeNext    = ram_we;
        ramAddrNext  = ram_addr;
        ramWdataNext = ram_wdata;
        ifDoneNext   = 1'b0;
        memDoneNext  = 1'b0;
        ifRdataNext  = if_rdata;
        memRdataNext = mem_rdata;

        unique case (state)
            IDLE: begin
                if (grantData) begin
                    stateNext    = BUSY_D;
                    ramEnNext    = 1'b1;
                    ramWeNext    = mem_wr;
                    ramAddrNext  = mem_addr;
                    ramWdataNext = mem_wdata;
                    if (if_req && streak < STREAK_MAX)
                        streakNext = streak + 4'd1;
                end else if (if_req) begin
                    stateNext   = BUSY_F;
                    ramEnNext   = 1'b1;
                    ramWeNext   = 1'b0;
                    ramAddrNext = if_addr;
                    streakNext  = '0;
                end
            end
            BUSY_D: begin
                if (ram_ready) begin
                    stateNext   = DONE;
                    ramEnNext   = 1'b0;
                    ramWeNext   = 1'b0;
                    memDoneNext = 1'b1;
                    // a write (including rd+wr) leaves the load data alone
                    if (!ram_we)
                        memRdataNext = ram_rdata;
                end
            end
            BUSY_F: begin
                if (ram_ready) begin
                    stateNext   = DONE;
                    ramEnNext   = 1'b0;
                    ifDoneNext  = 1'b1;
                    ifRdataNext = ram_rdata;
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase

        // the streak only counts while fetch is actually waiting
        if (!if_req)
            streakNext = '0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and random stimulus for the memory
// port arbiter, checked by a queue-based scoreboard and monitor.
module tb_mem_port_arbiter;

    localparam int AW   = 16;
    localparam int DW   = 16;
    localparam int MAXS = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_done;
    logic          mem_rd;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_done;
    logic          stall_if;
    logic          stall_mem;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic          ram_ready;

    mem_port_arbiter #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .MAX_DATA_STREAK(MAXS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .if_req(if_req),
        .if_addr(if_addr),
        .if_rdata(if_rdata),
        .if_done(if_done),
        .mem_rd(mem_rd),
        .mem_wr(mem_wr),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_done(mem_done),
        .stall_if(stall_if),
        .stall_mem(stall_mem),
        .ram_en(ram_en),
        .ram_we(ram_we),
        .ram_addr(ram_addr),
        .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata),
        .ram_ready(ram_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
    } txn_t;

    txn_t          ifQ[$];
    txn_t          memQ[$];
    bit            grantLog[$];
    logic [DW-1:0] ramArr [65536];
    logic [DW-1:0] refMem [65536];
    int            checks = 0;
    int            fails = 0;
    int            respMode = 0;
    int            enCycles = 0;

    function automatic logic [DW-1:0] initWord(input int a);
        return DW'(a * 7) ^ 16'h5A5A;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic failNow(input string name, input string what);
        checks++;
        fails++;
        $display("FAIL %s: %s", name, what);
    endtask

    // Memory model: 0 = random latency (ready noise while idle),
    // 1 = ready in the third enabled cycle, 2 = never ready.
    always @(negedge clk) begin
        if (ram_en) enCycles++;
        else enCycles = 0;
        ram_rdata = DW'($urandom);
        ram_ready = 1'b0;
        if (ram_en) begin
            case (respMode)
                1: ram_ready = (enCycles == 3);
                2: ram_ready = 1'b0;
                default: ram_ready = (enCycles >= 4) ||
                                     ($urandom_range(0, 1) == 1);
            endcase
            if (ram_ready) begin
                ram_rdata = ramArr[ram_addr];
                if (ram_we) ramArr[ram_addr] = ram_wdata;
            end
        end else if (respMode == 0) begin
            ram_ready = ($urandom_range(0, 1) == 1);
        end
    end

    // Monitor: grant side from the priority/streak rule, then the
    // granted access and its completion against the queued expectation.
    logic          prevEn, prevIfReq, prevDReq, prevIfDone, prevMemDone;
    logic [DW-1:0] expIfRdata, expMemRdata;
    int            streakM;
    bit            wantData;
    txn_t          mt;

    always @(negedge clk) begin
        if (rst) begin
            prevEn      = 1'b0;
            prevIfReq   = 1'b0;
            prevDReq    = 1'b0;
            prevIfDone  = 1'b0;
            prevMemDone = 1'b0;
            expIfRdata  = '0;
            expMemRdata = '0;
            streakM     = 0;
        end else begin
            check("stall_if", stall_if, if_req & ~if_done);
            check("stall_mem", stall_mem,
                  (mem_rd | mem_wr) & ~mem_done);
            if (ram_en && !prevEn) begin
                wantData = prevDReq && (streakM < MAXS || !prevIfReq);
                if (!prevDReq && !prevIfReq) begin
                    failNow("spurious_grant", "grant with no request");
                end else if (wantData) begin
                    grantLog.push_back(1'b1);
                    if (memQ.size() == 0) begin
                        failNow("data_grant", "no data access expected");
                    end else begin
                        check("data_addr", ram_addr, memQ[0].addr);
                        check("data_we", ram_we, memQ[0].we);
                        if (memQ[0].we)
                            check("data_wdata", ram_wdata, memQ[0].wdata);
                    end
                    if (prevIfReq)
                        streakM = (streakM < MAXS) ? streakM + 1 : MAXS;
                    else
                        streakM = 0;
                end else begin
                    grantLog.push_back(1'b0);
                    if (ifQ.size() == 0) begin
                        failNow("fetch_grant", "no fetch expected");
                    end else begin
                        check("fetch_addr", ram_addr, ifQ[0].addr);
                        check("fetch_we", ram_we, 0);
                    end
                    streakM = 0;
                end
            end else if (!prevIfReq) begin
                streakM = 0;
            end

            if (if_done) begin
                check("if_done_pulse", prevIfDone, 0);
                if (ifQ.size() == 0) begin
                    failNow("if_done", "unexpected fetch completion");
                end else begin
                    mt = ifQ.pop_front();
                    expIfRdata = mt.rdata;
                end
                check("if_rdata", if_rdata, expIfRdata);
            end else begin
                check("if_rdata_hold", if_rdata, expIfRdata);
            end

            if (mem_done) begin
                check("mem_done_pulse", prevMemDone, 0);
                if (memQ.size() == 0) begin
                    failNow("mem_done", "unexpected data completion");
                end else begin
                    mt = memQ.pop_front();
                    if (!mt.we) expMemRdata = mt.rdata;
                end
                check("mem_rdata", mem_rdata, expMemRdata);
            end else begin
                check("mem_rdata_hold", mem_rdata, expMemRdata);
            end

            prevEn      = ram_en;
            prevIfReq   = if_req;
            prevDReq    = mem_rd | mem_wr;
            prevIfDone  = if_done;
            prevMemDone = mem_done;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issueFetch(input logic [AW-1:0] a);
        txn_t t;
        t.addr  = a;
        t.we    = 1'b0;
        t.wdata = '0;
        t.rdata = refMem[a];
        ifQ.push_back(t);
        if_addr = a;
        if_req  = 1'b1;
    endtask

    task automatic issueData(input logic rd, input logic wr,
                             input logic [AW-1:0] a,
                             input logic [DW-1:0] d);
        txn_t t;
        t.addr  = a;
        t.we    = wr;
        t.wdata = d;
        t.rdata = refMem[a];
        if (wr) refMem[a] = d;
        memQ.push_back(t);
        mem_addr  = a;
        mem_wdata = d;
        mem_rd    = rd;
        mem_wr    = wr;
    endtask

    task automatic waitMemDone(input string name);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!mem_done && n < 40);
        check(name, mem_done, 1);
    endtask

    task automatic waitRamEn(input string name);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!ram_en && n < 40);
        check(name, ram_en, 1);
    endtask

    int            n, fetches, doneCnt, k;
    bit            stallOk, fetchDone, ifBusy, dBusy;
    bit            expPat [10];
    logic [DW-1:0] lastRead, rd16, wd16;
    logic [AW-1:0] ad16;

    initial begin
        rst = 1'b1;
        if_req = 1'b0;
        if_addr = '0;
        mem_rd = 1'b0;
        mem_wr = 1'b0;
        mem_addr = '0;
        mem_wdata = '0;
        ram_ready = 1'b0;
        ram_rdata = '0;
        for (int i = 0; i < 65536; i++) begin
            ramArr[i] = initWord(i);
            refMem[i] = initWord(i);
        end
        expPat = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ram_en", ram_en, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_wdata", ram_wdata, 0);
        check("rst_if_rdata", if_rdata, 0);
        check("rst_mem_rdata", mem_rdata, 0);
        check("rst_if_done", if_done, 0);
        check("rst_mem_done", mem_done, 0);
        check("rst_stall_if", stall_if, 0);
        rst = 1'b0;
        tick();
        tick();

        // lone fetch, memory ready in its third enabled cycle
        respMode = 1;
        ramArr[16'h0010] = 16'hBEEF;
        refMem[16'h0010] = 16'hBEEF;
        issueFetch(16'h0010);
        n = 0;
        do begin
            tick();
            n++;
            if (n == 2) begin
                check("lone_ram_en", ram_en, 1);
                check("lone_ram_we", ram_we, 0);
                check("lone_ram_addr", ram_addr, 16'h0010);
            end
        end while (!if_done && n < 40);
        check("lone_latency", n, 4);
        if_req = 1'b0;
        tick();
        check("lone_done_single", if_done, 0);
        repeat (3) tick();
        check("lone_rdata_hold", if_rdata, 16'hBEEF);

        // simultaneous fetch and store: store first
        respMode = 0;
        grantLog.delete();
        issueFetch(16'h0030);
        issueData(1'b0, 1'b1, 16'h0020, 16'h1234);
        stallOk = 1'b1;
        fetchDone = 1'b0;
        n = 0;
        while (!fetchDone && n < 60) begin
            tick();
            n++;
            if (mem_done) mem_wr = 1'b0;
            if (if_done) begin
                if_req = 1'b0;
                fetchDone = 1'b1;
            end else if (!stall_if) begin
                stallOk = 1'b0;
            end
        end
        check("simul_fetch_done", fetchDone, 1);
        check("simul_stall_held", stallOk, 1);
        check("simul_grants", grantLog.size(), 2);
        if (grantLog.size() >= 2) begin
            check("simul_first_data", grantLog[0], 1);
            check("simul_then_fetch", grantLog[1], 0);
        end
        tick();

        // starvation guard: fetch held, data reasserted every time
        grantLog.delete();
        issueFetch(16'h0040);
        issueData(1'b1, 1'b0, 16'h8000, 16'h0000);
        fetches = 0;
        n = 0;
        while (fetches < 2 && n < 400) begin
            tick();
            n++;
            if (mem_done)
                issueData(1'b1, 1'b0,
                          16'h8000 + 16'($urandom_range(0, 15)), '0);
            if (if_done) begin
                fetches++;
                if (fetches < 2) issueFetch(16'h0041);
                else if_req = 1'b0;
            end
        end
        check("starve_fetches", fetches, 2);
        waitMemDone("starve_tail_done");
        mem_rd = 1'b0;
        check("starve_grants", grantLog.size(), 11);
        if (grantLog.size() >= 10) begin
            for (int i = 0; i < 10; i++)
                check($sformatf("starve_grant%0d", i),
                      grantLog[i], expPat[i]);
        end
        tick();

        // illegal rd+wr: write wins, load data untouched
        lastRead = refMem[16'h8005];
        issueData(1'b1, 1'b0, 16'h8005, '0);
        waitMemDone("illegal_pre_done");
        mem_rd = 1'b0;
        tick();
        issueData(1'b1, 1'b1, 16'h8006, 16'h4321);
        waitRamEn("illegal_grant");
        check("illegal_we", ram_we, 1);
        waitMemDone("illegal_done");
        mem_rd = 1'b0;
        mem_wr = 1'b0;
        check("illegal_rdata_kept", mem_rdata, lastRead);
        tick();
        issueData(1'b1, 1'b0, 16'h8006, '0);
        waitMemDone("illegal_readback_done");
        mem_rd = 1'b0;
        check("illegal_write_landed", mem_rdata, 16'h4321);
        tick();

        // withdrawn read still completes exactly once
        respMode = 1;
        grantLog.delete();
        issueData(1'b1, 1'b0, 16'h8007, '0);
        waitRamEn("wd_grant");
        tick();
        mem_rd = 1'b0;
        doneCnt = 0;
        repeat (12) begin
            tick();
            if (mem_done) doneCnt++;
        end
        check("wd_done_once", doneCnt, 1);
        check("wd_one_access", grantLog.size(), 1);

        // reset in the middle of a data access
        respMode = 2;
        issueData(1'b1, 1'b0, 16'h8008, '0);
        waitRamEn("rst_mid_grant");
        @(posedge clk);
        #3;
        rst = 1'b1;
        mem_rd = 1'b0;
        memQ.delete();
        ifQ.delete();
        #1;
        check("rst_mid_ram_en", ram_en, 0);
        check("rst_mid_ram_we", ram_we, 0);
        check("rst_mid_ram_addr", ram_addr, 0);
        check("rst_mid_ram_wdata", ram_wdata, 0);
        check("rst_mid_if_rdata", if_rdata, 0);
        check("rst_mid_mem_rdata", mem_rdata, 0);
        check("rst_mid_mem_done", mem_done, 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        respMode = 0;
        repeat (5) begin
            tick();
            check("rst_after_idle", ram_en, 0);
        end

        // random traffic
        ifBusy = 1'b0;
        dBusy = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            tick();
            if (if_done) begin
                if_req = 1'b0;
                ifBusy = 1'b0;
            end
            if (mem_done) begin
                mem_rd = 1'b0;
                mem_wr = 1'b0;
                dBusy = 1'b0;
            end
            if (!ifBusy && $urandom_range(0, 3) != 0) begin
                issueFetch(16'h0100 + 16'($urandom_range(0, 255)));
                ifBusy = 1'b1;
            end
            if (!dBusy && $urandom_range(0, 2) != 0) begin
                k = $urandom_range(0, 9);
                ad16 = 16'h8000 + 16'($urandom_range(0, 15));
                wd16 = 16'($urandom);
                rd16 = '0;
                if (k < 5) issueData(1'b1, 1'b0, ad16, rd16);
                else if (k < 9) issueData(1'b0, 1'b1, ad16, wd16);
                else issueData(1'b1, 1'b1, ad16, wd16);
                dBusy = 1'b1;
            end
        end
        n = 0;
        while ((ifBusy || dBusy) && n < 100) begin
            tick();
            n++;
            if (if_done) begin
                if_req = 1'b0;
                ifBusy = 1'b0;
            end
            if (mem_done) begin
                mem_rd = 1'b0;
                mem_wr = 1'b0;
                dBusy = 1'b0;
            end
        end
        if (ifBusy || dBusy)
            failNow("drain", "accesses still open after 100 cycles");
        repeat (3) tick();
        check("queues_empty", ifQ.size() + memQ.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
